// File: rtl/backtrack_ctrl_pkg.sv
// Shared definitions for the maze backtrack controller: turn codes, FSM encoding, default stack size.
package backtrack_ctrl_pkg;
    localparam int DEPTH_DEFAULT = 49;
    localparam int CW_DEFAULT    = 2;

    localparam logic [1:0] STRAIGHT = 2'b00;
    localparam logic [1:0] LEFT     = 2'b01;
    localparam logic [1:0] RIGHT    = 2'b10;
    localparam logic [1:0] UTURN    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_PUSH_HI,
        S_PUSH_LO,
        S_POP_HI,
        S_POP_CAP,
        S_MOVE,
        S_DONE
    } state_t;
endpackage

// File: rtl/backtrack_ctrl_turn_invert.sv
// Maps a recorded turn to the turn that retraces it: left and right swap, straight and U-turn are kept.
module turn_invert
    import backtrack_ctrl_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic [CW-1:0] code_in,
    output logic [CW-1:0] code_out
);
    always_comb begin
        code_out = code_in;
        if (code_in == CW'(LEFT))
            code_out = CW'(RIGHT);
        else if (code_in == CW'(RIGHT))
            code_out = CW'(LEFT);
    end
endmodule

// File: rtl/backtrack_ctrl.sv
// Records turns onto an external edge-triggered stack while exploring, then replays them inverted in LIFO order.
// IDLE/REC: wait / record turns | PUSH_HI/PUSH_LO: push pulse / gap | POP_HI/POP_CAP: pop pulse / capture | MOVE/DONE: execute / finished
module backtrack_ctrl
    import backtrack_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          explore,
    input  logic          turn_valid,
    input  logic [CW-1:0] turn_code,
    input  logic          node_done,
    output logic          push,
    output logic [CW-1:0] push_val,
    output logic          pop,
    input  logic [CW-1:0] pop_val,
    output logic          move_valid,
    output logic [CW-1:0] move_code,
    output logic [5:0]    depth,
    output logic          done,
    output logic          err
);
    state_t        state, state_nx;
    logic [CW-1:0] push_val_nx;
    logic [CW-1:0] cap, cap_nx;
    logic [CW-1:0] cap_inv;
    logic [5:0]    depth_nx;
    logic          err_nx;
    logic          full;

    assign full = (depth >= 6'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            push_val <= '0;
            cap      <= '0;
            depth    <= '0;
            err      <= 1'b0;
        end else if (en) begin
            state    <= state_nx;
            push_val <= push_val_nx;
            cap      <= cap_nx;
            depth    <= depth_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        push_val_nx = push_val;
        cap_nx      = cap;
        depth_nx    = depth;
        err_nx      = err;
        case (state)
            S_IDLE: begin
                if (explore)
                    state_nx = S_REC;
            end
            S_REC: begin
                if (!explore) begin
                    state_nx = (depth != '0) ? S_POP_HI : S_DONE;
                    if (turn_valid)
                        err_nx = 1'b1;
                end else if (turn_valid) begin
                    if (!full) begin
                        push_val_nx = turn_code;
                        state_nx    = S_PUSH_HI;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_PUSH_HI: begin
                state_nx = S_PUSH_LO;
                if (turn_valid)
                    err_nx = 1'b1;
            end
            S_PUSH_LO: begin
                state_nx = S_REC;
                if (!full)
                    depth_nx = depth + 6'd1;
                if (turn_valid)
                    err_nx = 1'b1;
            end
            S_POP_HI: begin
                state_nx = S_POP_CAP;
            end
            S_POP_CAP: begin
                // pop_val is the stack's registered answer to the pulse in POP_HI
                cap_nx   = pop_val;
                state_nx = S_MOVE;
                if (depth != '0)
                    depth_nx = depth - 6'd1;
            end
            S_MOVE: begin
                if (node_done)
                    state_nx = (depth != '0) ? S_POP_HI : S_DONE;
            end
            S_DONE: begin
                if (explore)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    turn_invert #(.CW(CW)) u_turn_invert (
        .code_in  (cap),
        .code_out (cap_inv)
    );

    assign push       = (state == S_PUSH_HI);
    assign pop        = (state == S_POP_HI);
    assign move_valid = (state == S_MOVE);
    assign move_code  = move_valid ? cap_inv : '0;
    assign done       = (state == S_DONE);
endmodule

// File: tb/tb_backtrack_ctrl.sv
// Scoreboard bench for backtrack_ctrl with an edge-triggered stack model and a LIFO reference of recorded turns.
module tb_backtrack_ctrl;
    localparam int DEPTH = 49;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       explore = 1'b0;
    logic       turn_valid = 1'b0;
    logic [1:0] turn_code = 2'b00;
    logic       node_done = 1'b0;
    logic       push, pop, move_valid, done, err;
    logic [1:0] push_val, pop_val, move_code;
    logic [5:0] depth;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [1:0] exp_push_q[$];
    logic [1:0] exp_move_q[$];
    logic [1:0] model_stack[$];
    logic       exp_err = 1'b0;

    always #5 clk = ~clk;

    backtrack_ctrl #(.DEPTH(DEPTH), .CW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .explore    (explore),
        .turn_valid (turn_valid),
        .turn_code  (turn_code),
        .node_done  (node_done),
        .push       (push),
        .push_val   (push_val),
        .pop        (pop),
        .pop_val    (pop_val),
        .move_valid (move_valid),
        .move_code  (move_code),
        .depth      (depth),
        .done       (done),
        .err        (err)
    );

    // Downstream stack: acts on rising edges of push/pop, frozen by the shared enable.
    logic [1:0] stk [0:63];
    int         sp;
    logic       push_d, pop_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp      <= 0;
            push_d  <= 1'b0;
            pop_d   <= 1'b0;
            pop_val <= 2'b00;
        end else if (en) begin
            push_d <= push;
            pop_d  <= pop;
            if (push && !push_d && sp < DEPTH) begin
                stk[sp] <= push_val;
                sp      <= sp + 1;
            end
            if (pop && !pop_d && sp > 0) begin
                pop_val <= stk[sp-1];
                sp      <= sp - 1;
            end else begin
                pop_val <= 2'b00;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [1:0] inv(input logic [1:0] c);
        return (c == 2'd1 || c == 2'd2) ? 2'(3 - c) : c;
    endfunction

    // Monitor: pops expectations whenever the DUT starts a push pulse or a move.
    logic push_prev = 1'b0, mv_prev = 1'b0;
    int   hi_len = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                push_prev = 1'b0;
                mv_prev   = 1'b0;
                hi_len    = 0;
            end else begin
                if (push && !push_prev) begin
                    chk("push_expected", int'(exp_push_q.size() > 0), 1);
                    if (exp_push_q.size() > 0)
                        chk("push_val", push_val, exp_push_q.pop_front());
                    hi_len = 0;
                end
                if (push && en)
                    hi_len++;
                if (!push && push_prev)
                    chk("push_width", hi_len, 1);
                if (move_valid && !mv_prev) begin
                    chk("move_expected", int'(exp_move_q.size() > 0), 1);
                    if (exp_move_q.size() > 0)
                        chk("move_code", move_code, exp_move_q.pop_front());
                end
                push_prev = push;
                mv_prev   = move_valid;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_push_q.delete();
        exp_move_q.delete();
        model_stack.delete();
        exp_err    = 1'b0;
        explore    = 1'b0;
        turn_valid = 1'b0;
        node_done  = 1'b0;
        en         = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic start_explore();
        explore = 1'b1;
        tick(3);
    endtask

    task automatic turn(input logic [1:0] code, input int gap, input bit busy);
        turn_valid = 1'b1;
        turn_code  = code;
        if (!busy && model_stack.size() < DEPTH) begin
            exp_push_q.push_back(code);
            model_stack.push_back(code);
        end else begin
            exp_err = 1'b1;
        end
        tick(1);
        turn_valid = 1'b0;
        if (gap > 1)
            tick(gap - 1);
    endtask

    task automatic run_return();
        int n;
        int w;
        n = model_stack.size();
        for (int i = n - 1; i >= 0; i--)
            exp_move_q.push_back(inv(model_stack[i]));
        model_stack.delete();
        explore = 1'b0;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!move_valid && w < 20) begin
                tick(1);
                w++;
            end
            chk("move_reached", move_valid, 1);
            chk("depth_in_move", depth, n - 1 - k);
            node_done = 1'b1;
            tick(1);
            node_done = 1'b0;
        end
        w = 0;
        while (!done && w < 20) begin
            tick(1);
            w++;
        end
        chk("done", done, 1);
        chk("depth_at_done", depth, 0);
        chk("stack_empty", sp, 0);
        chk("move_q_drained", exp_move_q.size(), 0);
        chk("push_q_drained", exp_push_q.size(), 0);
    endtask

    initial begin
        int n;
        int sp0;
        tick(1);
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_depth", depth, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_move_valid", move_valid, 0);
        do_reset();

        // Three turns with 4-cycle gaps, then the inverted LIFO return run.
        start_explore();
        turn(2'b01, 4, 0);
        turn(2'b10, 4, 0);
        turn(2'b00, 4, 0);
        chk("depth_after_3", depth, 3);
        chk("stack_sp_3", sp, 3);
        chk("err_clean", err, 0);
        run_return();

        // Random runs back to back; round 0 has no turns and goes straight to DONE.
        for (int r = 0; r < 4; r++) begin
            start_explore();
            chk("restart_depth", depth, 0);
            n = (r == 0) ? 0 : $urandom_range(1, 12);
            for (int i = 0; i < n; i++)
                turn(2'($urandom_range(0, 3)), $urandom_range(3, 6), 0);
            chk("rand_depth", depth, model_stack.size());
            chk("rand_err", err, exp_err);
            run_return();
        end

        // Strobe while busy, then freeze the push pulse with en low.
        do_reset();
        start_explore();
        turn(2'b11, 1, 0);
        turn(2'b01, 4, 1);
        chk("busy_err", err, 1);
        chk("busy_depth", depth, 1);
        sp0 = sp;
        turn(2'b10, 1, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("frozen_push", push, 1);
            chk("frozen_sp", sp, sp0);
            chk("frozen_depth", depth, 1);
        end
        en = 1'b1;
        tick(3);
        chk("unfrozen_sp", sp, sp0 + 1);
        chk("unfrozen_depth", depth, 2);
        run_return();
        chk("err_sticky", err, 1);

        // Fill to capacity; the turn beyond it is dropped.
        do_reset();
        start_explore();
        for (int i = 0; i < DEPTH; i++)
            turn(2'($urandom_range(0, 3)), 3, 0);
        chk("full_depth", depth, DEPTH);
        chk("full_err_before", err, 0);
        turn(2'b01, 4, 0);
        chk("full_err", err, exp_err);
        chk("full_depth_after", depth, DEPTH);
        chk("full_sp", sp, DEPTH);
        run_return();

        // Async reset in the middle of a return run.
        do_reset();
        start_explore();
        turn(2'b01, 3, 0);
        turn(2'b10, 3, 0);
        turn(2'b11, 3, 0);
        explore = 1'b0;
        n = 0;
        while (!move_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("pre_rst_move", move_valid, 1);
        chk("pre_rst_depth", depth, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_move_valid", move_valid, 0);
        chk("arst_move_code", move_code, 0);
        chk("arst_depth", depth, 0);
        chk("arst_push_val", push_val, 0);
        chk("arst_pop", pop, 0);
        chk("arst_done", done, 0);
        exp_push_q.delete();
        exp_move_q.delete();
        model_stack.delete();
        exp_err = 1'b0;
        tick(1);
        rst = 1'b0;
        start_explore();
        chk("post_rst_depth", depth, 0);
        turn(2'b10, 4, 0);
        chk("post_rst_depth1", depth, 1);
        run_return();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
